// File: rtl/mem_prog_ctrl_pkg.sv
// Shared definitions for the memory programmer: command codes, FSM states
// and the read-latency counter width.
package mem_prog_ctrl_pkg;

    typedef enum logic [1:0] {
        CMD_WRITE  = 2'd0,
        CMD_VERIFY = 2'd1,
        CMD_LOAD   = 2'd2,
        CMD_READ   = 2'd3
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RD_WAIT,
        ST_RD_CAP,
        ST_INC
    } state_t;

    // Holds RD_LATENCY-1 for RD_LATENCY in 1..4.
    localparam int unsigned LAT_W = 2;

endpackage

// File: rtl/mem_prog_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stable-level debounce and a
// one-cycle pulse on each accepted press (release gives no pulse).
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // cnt counts consecutive synchronised samples that differ from level;
    // the DEBOUNCE_CYCLES-th such sample flips level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            cnt        <= '0;
            level      <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            sync1      <= raw;
            sync2      <= sync1;
            rise_pulse <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level      <= sync2;
                rise_pulse <= sync2;
                cnt        <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_prog_ctrl.sv
// Program-mode memory controller: turns debounced button steps into write,
// read, verify and address-load transactions on a single memory port.
module mem_prog_ctrl
    import mem_prog_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W          = 8,
    parameter int unsigned DATA_W          = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned RD_LATENCY      = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              step_btn,
    input  logic [1:0]        cmd,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] mem_q,
    output logic [ADDR_W-1:0] mem_adrs,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              wrapped,
    output logic              mismatch,
    output logic [7:0]        mismatch_cnt
);

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LATENCY - 1);

    state_t            state;
    state_t            state_nxt;
    cmd_t              cmd_q;
    logic [DATA_W-1:0] opnd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LAT_W-1:0]  lat_cnt;
    logic              step;
    logic              accept;
    logic              rd_diff;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_db (
        .clock     (clock),
        .reset     (reset),
        .raw       (step_btn),
        .level     (),
        .rise_pulse(step)
    );

    // Steps arriving while busy or disabled are dropped, never queued.
    assign accept  = step && enable && (state == ST_IDLE);
    assign rd_diff = (mem_q != opnd_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    unique case (cmd_t'(cmd))
                        CMD_WRITE:            state_nxt = ST_WRITE;
                        CMD_VERIFY, CMD_READ: state_nxt = ST_RD_WAIT;
                        CMD_LOAD:             state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_WRITE:   state_nxt = ST_INC;
            ST_RD_WAIT: if (lat_cnt == '0) state_nxt = ST_RD_CAP;
            ST_RD_CAP:  state_nxt = (cmd_q == CMD_VERIFY) ? ST_INC : ST_IDLE;
            ST_INC:     state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_wr_en = (state == ST_WRITE);
        busy      = (state != ST_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmd_q        <= CMD_WRITE;
            opnd_q       <= '0;
            addr_q       <= '0;
            lat_cnt      <= '0;
            rd_data      <= '0;
            wrapped      <= 1'b0;
            mismatch     <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            if (accept) begin
                cmd_q   <= cmd_t'(cmd);
                opnd_q  <= data_in;
                lat_cnt <= LAT_LOAD;
                // LOAD_ADDR finishes here, so it takes data_in rather than opnd_q.
                if (cmd_t'(cmd) == CMD_LOAD) begin
                    addr_q       <= ADDR_W'(data_in);
                    wrapped      <= 1'b0;
                    mismatch     <= 1'b0;
                    mismatch_cnt <= '0;
                end
            end
            if (state == ST_RD_WAIT && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end
            if (state == ST_RD_CAP) begin
                rd_data <= mem_q;
                if (cmd_q == CMD_VERIFY) begin
                    mismatch <= rd_diff;
                    if (rd_diff && mismatch_cnt != '1) begin
                        mismatch_cnt <= mismatch_cnt + 8'd1;
                    end
                end
            end
            if (state == ST_INC) begin
                addr_q <= addr_q + ADDR_W'(1);
                if (addr_q == '1) begin
                    wrapped <= 1'b1;
                end
            end
        end
    end

    assign mem_adrs = addr_q;
    assign mem_data = opnd_q;

endmodule

// File: tb/tb_mem_prog_ctrl.sv
// Directed bench for mem_prog_ctrl with DEBOUNCE_CYCLES=4, RD_LATENCY=1 and a
// one-cycle synchronous memory model.
module tb_mem_prog_ctrl;
    import mem_prog_ctrl_pkg::*;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       step_btn;
    logic [1:0] cmd;
    logic [7:0] data_in;
    logic [7:0] mem_q;
    logic [7:0] mem_adrs;
    logic [7:0] mem_data;
    logic       mem_wr_en;
    logic [7:0] rd_data;
    logic       busy;
    logic       wrapped;
    logic       mismatch;
    logic [7:0] mismatch_cnt;

    mem_prog_ctrl #(
        .ADDR_W         (8),
        .DATA_W         (8),
        .DEBOUNCE_CYCLES(4),
        .RD_LATENCY     (1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .step_btn    (step_btn),
        .cmd         (cmd),
        .data_in     (data_in),
        .mem_q       (mem_q),
        .mem_adrs    (mem_adrs),
        .mem_data    (mem_data),
        .mem_wr_en   (mem_wr_en),
        .rd_data     (rd_data),
        .busy        (busy),
        .wrapped     (wrapped),
        .mismatch    (mismatch),
        .mismatch_cnt(mismatch_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [7:0] mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h20] = 8'h55;
    end
    always @(posedge clock) begin
        if (mem_wr_en) mem[mem_adrs] <= mem_data;
        mem_q <= mem[mem_adrs];
    end

    int         busy_total = 0;
    logic [7:0] wr_log [$];
    always @(negedge clock) begin
        if (busy) busy_total <= busy_total + 1;
        if (mem_wr_en) wr_log.push_back(mem_adrs);
    end

    int n_checks = 0;
    int n_fail   = 0;
    int last_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_step(input logic [1:0] c, input logic [7:0] d);
        int b0;
        cmd      = c;
        data_in  = d;
        b0       = busy_total;
        step_btn = 1'b1;
        repeat (10) @(negedge clock);
        step_btn = 1'b0;
        repeat (10) @(negedge clock);
        last_busy = busy_total - b0;
    endtask

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] data;
        logic [7:0] adrs;
        logic [7:0] rd;
        logic       mm;
        logic [7:0] cnt;
        logic       wrp;
        int         busy;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int n0;
        int first;
        vecs[0]  = '{CMD_LOAD,   8'h10, 8'h10, 8'h00, 1'b0, 8'd0, 1'b0, 0};
        vecs[1]  = '{CMD_WRITE,  8'hA1, 8'h11, 8'h00, 1'b0, 8'd0, 1'b0, 2};
        vecs[2]  = '{CMD_WRITE,  8'hB2, 8'h12, 8'h00, 1'b0, 8'd0, 1'b0, 2};
        vecs[3]  = '{CMD_WRITE,  8'hC3, 8'h13, 8'h00, 1'b0, 8'd0, 1'b0, 2};
        vecs[4]  = '{CMD_LOAD,   8'hFE, 8'hFE, 8'h00, 1'b0, 8'd0, 1'b0, 0};
        vecs[5]  = '{CMD_WRITE,  8'h11, 8'hFF, 8'h00, 1'b0, 8'd0, 1'b0, 2};
        vecs[6]  = '{CMD_WRITE,  8'h22, 8'h00, 8'h00, 1'b0, 8'd0, 1'b1, 2};
        vecs[7]  = '{CMD_LOAD,   8'h00, 8'h00, 8'h00, 1'b0, 8'd0, 1'b0, 0};
        vecs[8]  = '{CMD_LOAD,   8'h20, 8'h20, 8'h00, 1'b0, 8'd0, 1'b0, 0};
        vecs[9]  = '{CMD_VERIFY, 8'h55, 8'h21, 8'h55, 1'b0, 8'd0, 1'b0, 3};
        vecs[10] = '{CMD_VERIFY, 8'h66, 8'h22, 8'h00, 1'b1, 8'd1, 1'b0, 3};
        vecs[11] = '{CMD_READ,   8'h00, 8'h22, 8'h00, 1'b1, 8'd1, 1'b0, 2};

        reset = 1'b1; enable = 1'b1; step_btn = 1'b0; cmd = '0; data_in = '0;
        repeat (3) @(negedge clock);
        check("rst_adrs", mem_adrs, 8'h00);
        check("rst_wr_en", mem_wr_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_status", {wrapped, mismatch, mismatch_cnt, rd_data, mem_data}, '0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Reset landing in the middle of a WRITE.
        do_step(CMD_LOAD, 8'h33);
        check("pre_rst_adrs", mem_adrs, 8'h33);
        cmd = CMD_WRITE; data_in = 8'h77; step_btn = 1'b1;
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (mem_wr_en) begin first = k; break; end
        end
        check("midwr_seen", (first != 0), 1'b1);
        reset = 1'b1; step_btn = 1'b0;
        #1;
        check("midwr_wr_en", mem_wr_en, 1'b0);
        check("midwr_busy", busy, 1'b0);
        check("midwr_adrs", mem_adrs, 8'h00);
        check("midwr_status", {wrapped, mismatch, mismatch_cnt, mem_data}, '0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("midwr_mem", mem[8'h33], 8'h00);
        n0 = wr_log.size();

        for (int i = 0; i < 12; i++) begin
            do_step(vecs[i].cmd, vecs[i].data);
            check($sformatf("v%0d_adrs", i), mem_adrs, vecs[i].adrs);
            check($sformatf("v%0d_data", i), mem_data, vecs[i].data);
            check($sformatf("v%0d_rd", i), rd_data, vecs[i].rd);
            check($sformatf("v%0d_mm", i), mismatch, vecs[i].mm);
            check($sformatf("v%0d_cnt", i), mismatch_cnt, vecs[i].cnt);
            check($sformatf("v%0d_wrap", i), wrapped, vecs[i].wrp);
            check($sformatf("v%0d_busy", i), last_busy, vecs[i].busy);
        end
        check("wr_count", wr_log.size() - n0, 5);
        if (wr_log.size() - n0 == 5) begin
            check("wr_a0", wr_log[n0],     8'h10);
            check("wr_a1", wr_log[n0 + 1], 8'h11);
            check("wr_a2", wr_log[n0 + 2], 8'h12);
            check("wr_a3", wr_log[n0 + 3], 8'hFE);
            check("wr_a4", wr_log[n0 + 4], 8'hFF);
        end
        check("mem_10", mem[8'h10], 8'hA1);
        check("mem_12", mem[8'h12], 8'hC3);
        check("mem_ff", mem[8'hFF], 8'h22);

        // Bounce: 2-cycle toggles never settle; the held press is accepted
        // at the 7th cycle (2 sync + 4 debounce + 1 accept).
        cmd = CMD_WRITE; data_in = 8'h5A;
        n0 = wr_log.size();
        for (int i = 0; i < 10; i++) begin
            step_btn = (i % 2 == 0);
            repeat (2) @(negedge clock);
        end
        check("bounce_no_wr", wr_log.size() - n0, 0);
        step_btn = 1'b1;
        first = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            if (mem_wr_en) begin first = k; break; end
        end
        check("bounce_latency", first, 7);
        repeat (10) @(negedge clock);
        step_btn = 1'b0;
        repeat (12) @(negedge clock);
        check("bounce_one_wr", wr_log.size() - n0, 1);
        check("bounce_mem", mem[8'h22], 8'h5A);
        check("bounce_adrs", mem_adrs, 8'h23);

        // Saturation of the mismatch counter.
        for (int i = 0; i < 300; i++) do_step(CMD_VERIFY, 8'hEE);
        check("sat_cnt", mismatch_cnt, 8'd255);
        check("sat_mm", mismatch, 1'b1);

        do_step(CMD_LOAD, 8'h20);
        check("clr_cnt", mismatch_cnt, 8'd0);
        check("clr_adrs", mem_adrs, 8'h20);

        // enable=0 drops the step entirely.
        enable = 1'b0;
        n0 = wr_log.size();
        do_step(CMD_WRITE, 8'h99);
        check("dis_adrs", mem_adrs, 8'h20);
        check("dis_busy", last_busy, 0);
        check("dis_no_wr", wr_log.size() - n0, 0);
        check("dis_mem", mem[8'h20], 8'h55);
        enable = 1'b1;

        // READ with enable dropping once busy: the read still completes.
        cmd = CMD_READ; data_in = 8'h00; step_btn = 1'b1;
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (busy) begin first = k; break; end
        end
        check("rd_started", (first != 0), 1'b1);
        enable = 1'b0;
        repeat (10) @(negedge clock);
        step_btn = 1'b0;
        repeat (10) @(negedge clock);
        check("rd_data", rd_data, 8'h55);
        check("rd_adrs", mem_adrs, 8'h20);
        check("rd_mm", mismatch, 1'b0);
        check("rd_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
